// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter slice.
//   - state_t    : arbiter sequencer states (IDLE / ACCESS / RESP)
//   - ST_*       : the same encodings as plain logic constants, which is what the
//                  sequencer register uses
//   - req_t      : request payload at default widths
//   - rr_pick    : 2-way round-robin pick, one-hot result
//   Optional build macro: DMEM_ARB_FIXED_PRIO_EN (consumed by rr_arb2).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

  // One-hot grant. With both requesters valid the one that was NOT granted
  // last time wins; a lone requester wins regardless of history.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                         input logic       last_grant);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_grant ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way grant generator for the data-memory arbiter.
//   Default build: round-robin on last_grant (reset value 1, so requester 0
//   wins the first contested grant). With DMEM_ARB_FIXED_PRIO_EN defined,
//   requester 0 always wins a contest and no history is kept.
//
//   Ports
//     clk   in   clock
//     rst   in   asynchronous active-low reset
//     en    in   arbitration window open (grant may be issued this cycle)
//     req   in   [1:0] request valids
//     gnt   out  [1:0] one-hot grant, only for a valid requester and only
//                when en is high; a grant is a handshake by construction
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  // No state in fixed-priority mode; clock and reset are kept on the port
  // list so both builds share one instantiation.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

`else

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) gnt = rr_pick(req, last_grant);
  end

  // History only moves on an actual handshake (any grant is one).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[1];
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter/sequencer for the single-port data memory.
//   Requester 0 = pipeline MEM stage, requester 1 = DMA/debug loader.
//   Each accepted request gets one ACCESS cycle on the memory bus followed by
//   one RESP cycle carrying a response pulse to its owner.
//   Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, req0 wins).
//
//   Handshake: a request transfers on a rising edge where reqN_valid and
//   reqN_ready are both high. Ready is combinational, only for the arbitration
//   winner, only in IDLE or RESP, and never while rst is low. A requester holds
//   valid and payload stable until it sees ready; payload is sampled only on
//   the handshake edge. rspN_valid is a one-cycle pulse with no back-pressure.
//
//   Ports
//     clk, rst                        clock, async active-low reset
//     reqN_valid/ready/we/addr/wdata  request channel of requester N
//     rspN_valid, rspN_rdata          response channel of requester N
//     mem_we, mem_addr, mem_wdata     memory command (write on the edge
//                                     ending ACCESS)
//     mem_rdata                       memory read data, combinational
//     dbg_state                       sequencer state (ST_* encoding)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic [1:0]    dbg_state
);

  logic [1:0]    state_q;
  logic [1:0]    state_d;

  // Request register: payload and owner of the access in flight.
  logic          req_we_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q;
  logic          owner_q;

  logic [DW-1:0] rsp0_rdata_q;
  logic [DW-1:0] rsp1_rdata_q;

  logic          arb_en;
  logic [1:0]    gnt;
  logic          hs;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration. Open in IDLE and RESP only; closed while reset is asserted so
  // no ready can leak out of an async reset.
  // ---------------------------------------------------------------------------
  assign arb_en = rst && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign hs         = gnt[0] | gnt[1];

  assign sel_we    = gnt[1] ? req1_we    : req0_we;
  assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
  assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hs) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = hs ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      owner_q      <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q <= state_d;

      if (hs) begin
        req_we_q    <= sel_we;
        req_addr_q  <= sel_addr;
        req_wdata_q <= sel_wdata;
        owner_q     <= gnt[1];
      end

      // The edge ending ACCESS both commits a write in the memory and captures
      // read data; a write response reports zero.
      if (state_q == ST_ACCESS) begin
        if (owner_q) rsp1_rdata_q <= req_we_q ? '0 : mem_rdata;
        else         rsp0_rdata_q <= req_we_q ? '0 : mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The request register only changes on a handshake, so the address
  // and write data naturally hold their last values outside ACCESS.
  // ---------------------------------------------------------------------------
  assign mem_we    = (state_q == ST_ACCESS) && req_we_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter. A transaction-level reference model predicts, per
//   cycle, which requester is accepted, the memory command in the following
//   cycle, and the response (data and cycle) two cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } treq_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  logic [DW-1:0] tb_mem [0:65535];
  bit            tb_wr  [0:65535];

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      tb_wr[mem_addr]  <= 1'b1;
    end
  end

  assign mem_rdata = tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr);

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [int];
  treq_t         q0[$];
  treq_t         q1[$];
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  int            ec0_q[$];
  int            ec1_q[$];
  int            gnt_log[$];
  int            gnt_cyc[$];
  logic [DW-1:0] last_rd [2];
  logic          m_last;
  logic          busy;
  logic          pres0, pres1;
  logic          acc_v;
  treq_t         acc_r;
  int            cyc;
  int            checks;
  int            passes;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic model_reset();
    m_last     = 1'b1;
    busy       = 1'b0;
    acc_v      = 1'b0;
    pres0      = 1'b0;
    pres1      = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    exp0_q.delete();
    exp1_q.delete();
    ec0_q.delete();
    ec1_q.delete();
  endtask

  // One clock cycle: compare this cycle's outputs with the model, then drive
  // the next inputs and predict the grant.
  task automatic step(input int gaps);
    logic          rv, exp_v;
    logic [DW-1:0] rd, e;
    logic [1:0]    exp_rdy;
    int            w;
    treq_t         r;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      rv    = (i == 0) ? rsp0_valid : rsp1_valid;
      rd    = (i == 0) ? rsp0_rdata : rsp1_rdata;
      exp_v = (i == 0) ? (ec0_q.size() > 0 && ec0_q[0] == cyc)
                       : (ec1_q.size() > 0 && ec1_q[0] == cyc);
      checks++;
      if (rv !== exp_v)
        $display("FAIL rsp%0d_valid cyc=%0d got=%b exp=%b", i, cyc, rv, exp_v);
      else passes++;
      if (exp_v) begin
        if (i == 0) begin e = exp0_q.pop_front(); void'(ec0_q.pop_front()); end
        else        begin e = exp1_q.pop_front(); void'(ec1_q.pop_front()); end
        last_rd[i] = e;
      end
      checks++;
      if (rd !== last_rd[i])
        $display("FAIL rsp%0d_rdata cyc=%0d got=%h exp=%h", i, cyc, rd, last_rd[i]);
      else passes++;
    end
    checks++;
    if (mem_we !== (acc_v && acc_r.we))
      $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, acc_v && acc_r.we);
    else passes++;
    if (acc_v) begin
      checks++;
      if (mem_addr !== acc_r.addr || (acc_r.we && mem_wdata !== acc_r.wdata))
        $display("FAIL mem_bus cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata,
                 acc_r.addr, acc_r.wdata);
      else passes++;
    end
    acc_v = 1'b0;

    if (!pres0 && q0.size() > 0 && (gaps == 0 || $urandom_range(0, 2) != 0)) pres0 = 1'b1;
    if (!pres1 && q1.size() > 0 && (gaps == 0 || $urandom_range(0, 2) != 0)) pres1 = 1'b1;
    req0_valid = pres0;
    req1_valid = pres1;
    if (pres0) begin
      req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
    end else begin
      req0_we = 1'($urandom_range(0, 1)); req0_addr = AW'($urandom); req0_wdata = $urandom;
    end
    if (pres1) begin
      req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
    end else begin
      req1_we = 1'($urandom_range(0, 1)); req1_addr = AW'($urandom); req1_wdata = $urandom;
    end
    #1;
    w = -1;
    if (!busy && rst) begin
      if (pres0 && pres1) w = FIXED ? 0 : (m_last ? 0 : 1);
      else if (pres0)     w = 0;
      else if (pres1)     w = 1;
    end
    exp_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    checks++;
    if ({req1_ready, req0_ready} !== exp_rdy)
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, {req1_ready, req0_ready}, exp_rdy);
    else passes++;
    busy = (w >= 0);
    if (w >= 0) begin
      m_last = w[0];
      if (w == 0) begin r = q0.pop_front(); pres0 = 1'b0; end
      else        begin r = q1.pop_front(); pres1 = 1'b0; end
      if (r.we) begin ref_mem[int'(r.addr)] = r.wdata; e = '0; end
      else e = ref_rd(r.addr);
      if (w == 0) begin exp0_q.push_back(e); ec0_q.push_back(cyc + 2); end
      else        begin exp1_q.push_back(e); ec1_q.push_back(cyc + 2); end
      acc_v = 1'b1;
      acc_r = r;
      gnt_log.push_back(w);
      gnt_cyc.push_back(cyc);
    end
  endtask

  task automatic run_traffic(input int gaps, input int budget);
    int n;
    n = 0;
    gnt_log.delete();
    gnt_cyc.delete();
    while (n < budget && (q0.size() > 0 || q1.size() > 0 || pres0 || pres1 ||
                          ec0_q.size() > 0 || ec1_q.size() > 0)) begin
      step(gaps);
      n++;
    end
    if (n >= budget) begin
      checks++;
      $display("FAIL traffic_timeout budget=%0d left q0=%0d q1=%0d", budget, q0.size(), q1.size());
    end
    step(0);
  endtask

  task automatic push_req(input int who, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    treq_t r;
    r.we = we; r.addr = a; r.wdata = d;
    if (who == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_we = 1'b1; req1_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00)
        $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready});
      else passes++;
      checks++;
      if (mem_we !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
          rsp0_rdata !== '0 || rsp1_rdata !== '0 || mem_addr !== '0 ||
          mem_wdata !== '0 || dbg_state !== 2'd0)
        $display("FAIL reset_outputs got=%b%b%b/%h/%h/%h/%h/%h exp=000/0/0/0/0/0",
                 mem_we, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
                 mem_addr, mem_wdata, dbg_state);
      else passes++;
    end
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL reset_first_grant got=%b exp=01", {req1_ready, req0_ready});
    else passes++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_write_read();
    push_req(0, 1'b1, 16'h0010, 32'hDEADBEEF);
    run_traffic(0, 20);
    checks++;
    if (rsp0_rdata !== 32'h0)
      $display("FAIL write_rsp_zero got=%h exp=00000000", rsp0_rdata);
    else passes++;
    push_req(0, 1'b0, 16'h0010, 32'h0);
    run_traffic(0, 20);
    checks++;
    if (rsp0_rdata !== 32'hDEADBEEF)
      $display("FAIL read_back got=%h exp=deadbeef", rsp0_rdata);
    else passes++;
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'b0, 16'h0001, 32'h0);
      push_req(1, 1'b0, 16'h0002, 32'h0);
    end
    run_traffic(0, 40);
    for (int k = 0; k < gnt_log.size(); k++) begin
      checks++;
      if (FIXED) begin
        if (gnt_log[k] !== ((k < 4) ? 0 : 1))
          $display("FAIL fixed_order k=%0d got=%0d exp=%0d", k, gnt_log[k], (k < 4) ? 0 : 1);
        else passes++;
      end else begin
        if (gnt_log[k] !== (k % 2))
          $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, gnt_log[k], k % 2);
        else passes++;
      end
      if (k > 0) begin
        checks++;
        if (gnt_cyc[k] - gnt_cyc[k-1] !== 2)
          $display("FAIL grant_spacing k=%0d got=%0d exp=2", k, gnt_cyc[k] - gnt_cyc[k-1]);
        else passes++;
      end
    end
    checks++;
    if (gnt_log.size() !== 8)
      $display("FAIL contention_count got=%0d exp=8", gnt_log.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    push_req(1, 1'b1, 16'hFFFF, 32'h12345678);
    push_req(1, 1'b0, 16'hFFFF, 32'h0);
    run_traffic(0, 20);
    checks++;
    if (rsp1_rdata !== 32'h12345678)
      $display("FAIL raw_top_addr got=%h exp=12345678", rsp1_rdata);
    else passes++;
    checks++;
    if (gnt_cyc.size() != 2 || gnt_cyc[1] - gnt_cyc[0] !== 2)
      $display("FAIL raw_spacing got=%0d grants exp=2 grants 2 apart", gnt_cyc.size());
    else passes++;
  endtask

`ifdef DMEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int i = 0; i < 6; i++) push_req(0, 1'b0, AW'(i + 32), 32'h0);
    push_req(1, 1'b0, 16'h0040, 32'h0);
    push_req(1, 1'b0, 16'h0041, 32'h0);
    run_traffic(0, 60);
    for (int k = 0; k < gnt_log.size(); k++) begin
      checks++;
      if (gnt_log[k] !== ((k < 6) ? 0 : 1))
        $display("FAIL fixed_prio k=%0d got=%0d exp=%0d", k, gnt_log[k], (k < 6) ? 0 : 1);
      else passes++;
    end
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : AW'($urandom_range(0, 7));
      push_req(0, 1'($urandom_range(0, 1)), a, $urandom);
      a = ($urandom_range(0, 4) == 0) ? 16'hFFFF : AW'($urandom_range(0, 7));
      push_req(1, 1'($urandom_range(0, 1)), a, $urandom);
    end
    run_traffic(1, 400);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    cyc++;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0020; req0_wdata = 32'h0;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL midrst_grant got=%b exp=01", {req1_ready, req0_ready});
    else passes++;
    @(negedge clk);
    cyc++;
    req0_valid = 1'b0;
    checks++;
    if (dbg_state !== 2'd1 || mem_we !== 1'b0 || mem_addr !== 16'h0020)
      $display("FAIL midrst_access got=%0d/%b/%h exp=1/0/0020", dbg_state, mem_we, mem_addr);
    else passes++;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dbg_state !== 2'd0 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0)
      $display("FAIL midrst_async got=%0d/%b/%b exp=0/0/0", dbg_state, rsp0_valid, req0_ready);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== '0)
        $display("FAIL midrst_hold got=%b%b/%h exp=00/0", rsp0_valid, rsp1_valid, rsp0_rdata);
      else passes++;
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(0);
    checks++;
    if (dbg_state !== 2'd0)
      $display("FAIL midrst_idle got=%0d exp=0", dbg_state);
    else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    cyc = 0;
    checks = 0;
    passes = 0;
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d passed=%0d total=%0d", cyc, passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
